// File: rtl/tqv_periph_initiator.sv
// Host-side initiator for the TinyQV peripheral port: accepts one read/write
// command at a time, drives the peripheral strobes and returns a response.
module tqv_periph_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  periph_address,
  output logic [31:0] periph_data_in,
  output logic [1:0]  periph_data_write_n,
  output logic [1:0]  periph_data_read_n,
  input  logic [31:0] periph_data_out,
  input  logic        periph_data_ready,
  output logic        busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  state_t             state, state_d;
  rsp_t               rsp, rsp_d;
  logic [1:0]         size, size_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               cmd_ready_d, rsp_valid_d, busy_d;
  logic [5:0]         addr_d;
  logic [31:0]        data_in_d;
  logic [1:0]         write_n_d, read_n_d;

  // Zero every byte above the transfer size.
  function automatic logic [31:0] size_mask(input logic [1:0] sz, input logic [31:0] v);
    case (sz)
      2'b00:   return {24'b0, v[7:0]};
      2'b01:   return {16'b0, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    state_d     = state;
    rsp_d       = rsp;
    size_d      = size;
    cnt_d       = cnt;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    addr_d      = periph_address;
    data_in_d   = periph_data_in;
    write_n_d   = periph_data_write_n;
    read_n_d    = periph_data_read_n;
    case (state)
      IDLE: if (cmd_valid && cmd_ready) begin
        cmd_ready_d = 1'b0;
        size_d      = cmd_size;
        if (cmd_size == 2'b11) begin
          // Illegal size: answer straight away without touching the bus.
          rsp_d       = '{err: 1'b1, rdata: 32'd0};
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cmd_write) begin
          addr_d    = cmd_addr;
          data_in_d = size_mask(cmd_size, cmd_wdata);
          write_n_d = cmd_size;
          state_d   = WRITE;
        end else begin
          addr_d   = cmd_addr;
          read_n_d = cmd_size;
          cnt_d    = '0;
          state_d  = READ;
        end
      end
      WRITE: begin
        write_n_d   = 2'b11;
        rsp_d       = '{err: 1'b0, rdata: 32'd0};
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      READ: begin
        cnt_d = cnt + 1'b1;
        // Ready takes priority over an expiring timeout in the same cycle.
        if (periph_data_ready) begin
          rsp_d       = '{err: 1'b0, rdata: size_mask(size, periph_data_out)};
          rsp_valid_d = 1'b1;
          read_n_d    = 2'b11;
          state_d     = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          rsp_d       = '{err: 1'b1, rdata: 32'd0};
          rsp_valid_d = 1'b1;
          read_n_d    = 2'b11;
          state_d     = RESP;
        end
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      rsp                 <= '0;
      size                <= 2'b00;
      cnt                 <= '0;
      cmd_ready           <= 1'b1;
      rsp_valid           <= 1'b0;
      busy                <= 1'b0;
      periph_address      <= 6'd0;
      periph_data_in      <= 32'd0;
      periph_data_write_n <= 2'b11;
      periph_data_read_n  <= 2'b11;
    end else begin
      state               <= state_d;
      rsp                 <= rsp_d;
      size                <= size_d;
      cnt                 <= cnt_d;
      cmd_ready           <= cmd_ready_d;
      rsp_valid           <= rsp_valid_d;
      busy                <= busy_d;
      periph_address      <= addr_d;
      periph_data_in      <= data_in_d;
      periph_data_write_n <= write_n_d;
      periph_data_read_n  <= read_n_d;
    end
  end

  assign rsp_rdata = rsp.rdata;
  assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_tqv_periph_initiator.sv
// Bench for tqv_periph_initiator: directed cases plus random transactions
// checked cycle by cycle against a transaction-level model.
module tb_tqv_periph_initiator;
  localparam int TO = 4;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_size;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [5:0]  periph_address;
  logic [31:0] periph_data_in, periph_data_out;
  logic [1:0]  periph_data_write_n, periph_data_read_n;
  logic        periph_data_ready, busy;

  int total = 0;
  int bad   = 0;

  tqv_periph_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .periph_address(periph_address), .periph_data_in(periph_data_in),
    .periph_data_write_n(periph_data_write_n), .periph_data_read_n(periph_data_read_n),
    .periph_data_out(periph_data_out), .periph_data_ready(periph_data_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Keep only the low 2^sz bytes of a word.
  function automatic logic [31:0] model_mask(input logic [1:0] sz, input logic [31:0] v);
    int nb;
    logic [63:0] lim;
    nb = 1 << sz;
    if (nb >= 4) return v;
    lim = 64'd1 << (8 * nb);
    return 32'(64'(v) % lim);
  endfunction

  // One command; lat = READ cycle on which data_ready rises (>TO means never),
  // hold = cycles rsp_ready stays low before the handshake.
  task automatic do_txn(input logic wr, input logic [1:0] sz, input logic [5:0] a,
                        input logic [31:0] wd, input int lat, input logic [31:0] rd_val,
                        input int hold);
    logic [31:0] exp_rd;
    logic        exp_err;
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    cmd_valid = 1; cmd_write = wr; cmd_size = sz; cmd_addr = a; cmd_wdata = wd;
    periph_data_ready = 1'($urandom_range(0, 1));
    tick;
    cmd_valid = 0; cmd_wdata = $urandom; cmd_addr = 6'($urandom);
    periph_data_ready = 0;
    exp_rd = 0;
    exp_err = 0;
    if (sz == 2'b11) begin
      exp_err = 1;
      chk("ill_write_n", periph_data_write_n, 2'b11);
      chk("ill_read_n", periph_data_read_n, 2'b11);
    end else if (wr) begin
      chk("wr_strobe", periph_data_write_n, sz);
      chk("wr_addr", periph_address, a);
      chk("wr_data", periph_data_in, model_mask(sz, wd));
      chk("wr_read_n", periph_data_read_n, 2'b11);
      chk("wr_rsp_early", rsp_valid, 0);
      chk("wr_busy", busy, 1);
      tick;
      chk("wr_strobe_off", periph_data_write_n, 2'b11);
    end else begin
      exp_err = 1;
      for (int i = 1; i <= TO; i++) begin
        chk("rd_strobe", periph_data_read_n, sz);
        chk("rd_addr", periph_address, a);
        chk("rd_write_n", periph_data_write_n, 2'b11);
        chk("rd_rsp_early", rsp_valid, 0);
        if (i == lat) begin
          periph_data_out = rd_val;
          periph_data_ready = 1;
          exp_err = 0;
          exp_rd = model_mask(sz, rd_val);
        end else begin
          periph_data_out = $urandom;
        end
        tick;
        if (i == lat) break;
      end
      chk("rd_strobe_off", periph_data_read_n, 2'b11);
    end
    for (int j = 0; j <= hold; j++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_cmd_ready", cmd_ready, 0);
      chk("rsp_busy", busy, 1);
      rsp_ready = (j == hold);
      tick;
    end
    rsp_ready = 0;
    periph_data_ready = 0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_size = 0; cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; periph_data_out = 0; periph_data_ready = 0;
    tick; tick;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_write_n", periph_data_write_n, 2'b11);
    chk("rst_read_n", periph_data_read_n, 2'b11);
    chk("rst_addr", periph_address, 0);
    chk("rst_data_in", periph_data_in, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    tick;

    do_txn(1, 2'b10, 6'h00, 32'h3F490FDB, 0, 0, 0);
    do_txn(0, 2'b10, 6'h02, 0, 3, 32'h3F3504F3, 1);
    do_txn(0, 2'b00, 6'h05, 0, 1, 32'hAABBCCDD, 0);
    do_txn(0, 2'b01, 6'h06, 0, 1, 32'hAABBCCDD, 0);
    do_txn(0, 2'b10, 6'h07, 0, 99, 0, 0);
    do_txn(0, 2'b01, 6'h08, 0, TO, 32'h12345678, 0);
    do_txn(1, 2'b11, 6'h09, 32'hFFFFFFFF, 0, 0, 5);
    do_txn(1, 2'b00, 6'h0A, 32'hDEADBEEF, 0, 0, 2);

    // Reset in the middle of a read drops the command at once.
    cmd_valid = 1; cmd_write = 0; cmd_size = 2'b10; cmd_addr = 6'h11;
    tick;
    cmd_valid = 0;
    tick;
    chk("pre_rst_read_n", periph_data_read_n, 2'b10);
    rst_n = 0;
    #1;
    chk("midrst_read_n", periph_data_read_n, 2'b11);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    #3;
    rst_n = 1;
    tick;
    do_txn(0, 2'b00, 6'h12, 0, 2, 32'h0BADF00D, 0);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_txn(1'($urandom_range(0, 1)), sz, 6'($urandom), $urandom,
             $urandom_range(1, TO + 2), $urandom, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
